// File: rtl/anita3_trigger_arbiter.sv
// Purpose: edge-detect, prescale and merge trigger sources (RF, PPS1, PPS2, soft) into one trigger pulse.
// Latency: a request raised after edge k is sampled at k+1 and gives trig_o after edge k+2.
// Backpressure: a qualified edge is dropped and counted when it meets holdoff, an active trigger or dead_i.
// Ports: clk250_i/rst_i (sync, active-high); trig_req_i/src_en_i/prescale_i are per-source controls;
//        holdoff_i sets the quiet time after each trigger; dead_i marks the buffer manager as full;
//        clr_lost_i clears lost_count_o; trig_o/trig_src_o go to the buffer manager; lost_o/lost_count_o/busy_o report status.
module anita3_trigger_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int PRESCALE_BITS = 8,
  parameter int HOLDOFF_BITS  = 8,
  parameter int LOST_BITS     = 16
) (
  input  logic                             clk250_i,
  input  logic                             rst_i,
  input  logic [NUM_SRC-1:0]               trig_req_i,
  input  logic [NUM_SRC-1:0]               src_en_i,
  input  logic [NUM_SRC*PRESCALE_BITS-1:0] prescale_i,
  input  logic [HOLDOFF_BITS-1:0]          holdoff_i,
  input  logic                             dead_i,
  input  logic                             clr_lost_i,
  output logic                             trig_o,
  output logic [NUM_SRC-1:0]               trig_src_o,
  output logic                             lost_o,
  output logic [LOST_BITS-1:0]             lost_count_o,
  output logic                             busy_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FIRE    = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic [1:0]              state;
  logic [HOLDOFF_BITS-1:0] hcnt;
  logic [NUM_SRC-1:0]      req_q;
  logic [NUM_SRC-1:0]      edge_det;
  logic [NUM_SRC-1:0]      qual;
  logic [NUM_SRC-1:0]      qual_r;
  logic                    lost_now;

  assign edge_det = trig_req_i & ~req_q;

  // Per-source prescale. Counters run independently of the FSM so the
  // decimation ratio stays fixed even while triggers are being dropped.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [PRESCALE_BITS-1:0] cnt;
    logic                     hit;

    // ">=" so that lowering the prescale below the running count
    // qualifies the very next edge instead of waiting for a wrap.
    assign hit     = cnt >= prescale_i[i*PRESCALE_BITS +: PRESCALE_BITS];
    assign qual[i] = edge_det[i] & src_en_i[i] & hit;

    always_ff @(posedge clk250_i) begin
      if (rst_i) begin
        cnt <= '0;
      end else if (edge_det[i] && src_en_i[i]) begin
        cnt <= hit ? '0 : cnt + 1'b1;
      end
    end
  end

  // Any qualified edge the FSM cannot turn into a trigger this cycle is lost.
  assign lost_now = (qual_r != '0) && ((state != IDLE) || dead_i);

  assign busy_o = (state != IDLE) || dead_i;

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state        <= IDLE;
      hcnt         <= '0;
      req_q        <= '1;  // a level already high at release is not an edge
      qual_r       <= '0;
      trig_o       <= 1'b0;
      trig_src_o   <= '0;
      lost_o       <= 1'b0;
      lost_count_o <= '0;
    end else begin
      req_q      <= trig_req_i;
      qual_r     <= qual;
      trig_o     <= 1'b0;
      trig_src_o <= '0;
      lost_o     <= lost_now;

      if (clr_lost_i) begin
        lost_count_o <= '0;
      end else if (lost_now && (lost_count_o != '1)) begin
        lost_count_o <= lost_count_o + 1'b1;
      end

      case (state)
        IDLE: begin
          if ((qual_r != '0) && !dead_i) begin
            state      <= FIRE;
            trig_o     <= 1'b1;
            trig_src_o <= qual_r;
            hcnt       <= holdoff_i;
          end
        end
        FIRE: begin
          state <= (hcnt != '0) ? HOLDOFF : IDLE;
        end
        HOLDOFF: begin
          hcnt <= hcnt - 1'b1;
          if (hcnt <= 1) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anita3_trigger_arbiter.sv
// Purpose: directed self-checking bench for anita3_trigger_arbiter.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after a rising edge.
// Backpressure: exercises holdoff, dead_i blocking, lost counting and saturation.
module tb_anita3_trigger_arbiter;

  logic        clk250;
  logic        rst;
  logic [3:0]  trig_req;
  logic [3:0]  src_en;
  logic [31:0] prescale;
  logic [7:0]  holdoff;
  logic        dead;
  logic        clr_lost;
  logic        trig;
  logic [3:0]  trig_src;
  logic        lost;
  logic [15:0] lost_count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int trig_cnt = 0;
  int lost_pulses = 0;
  logic [3:0] last_src = '0;
  int base;
  int lbase;

  anita3_trigger_arbiter #(
    .NUM_SRC(4), .PRESCALE_BITS(8), .HOLDOFF_BITS(8), .LOST_BITS(16)
  ) dut (
    .clk250_i     (clk250),
    .rst_i        (rst),
    .trig_req_i   (trig_req),
    .src_en_i     (src_en),
    .prescale_i   (prescale),
    .holdoff_i    (holdoff),
    .dead_i       (dead),
    .clr_lost_i   (clr_lost),
    .trig_o       (trig),
    .trig_src_o   (trig_src),
    .lost_o       (lost),
    .lost_count_o (lost_count),
    .busy_o       (busy)
  );

  initial clk250 = 1'b0;
  always #5 clk250 = ~clk250;

  // Event log, sampled mid-cycle.
  always @(negedge clk250) begin
    if (!rst && trig) begin
      trig_cnt <= trig_cnt + 1;
      last_src <= trig_src;
    end
    if (!rst && lost) lost_pulses <= lost_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk250);
    #1;
  endtask

  initial begin
    rst = 1'b1; trig_req = 4'b0001; src_en = 4'hF; prescale = '0;
    holdoff = '0; dead = 1'b0; clr_lost = 1'b0;
    repeat (3) tick();
    chk("rst_trig", {31'd0, trig}, 0);
    chk("rst_src", {28'd0, trig_src}, 0);
    chk("rst_lost", {31'd0, lost}, 0);
    chk("rst_lost_count", {16'd0, lost_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // Level high across reset release must not trigger.
    rst = 1'b0;
    repeat (5) tick();
    chk("t1_no_trig_at_release", trig_cnt, 0);
    trig_req = 4'b0000;
    repeat (2) tick();
    trig_req = 4'b0001;          // raised after edge k
    tick();                      // after k+1
    chk("t1_lat_k1", {31'd0, trig}, 0);
    tick();                      // after k+2
    chk("t1_lat_k2", {31'd0, trig}, 1);
    chk("t1_src", {28'd0, trig_src}, 32'h1);
    tick();
    chk("t1_one_cycle", {31'd0, trig}, 0);
    trig_req = 4'b0000;
    repeat (3) tick();

    // Soft source, prescale 2: every third pulse triggers.
    src_en = 4'h8; prescale = 32'h0200_0000; holdoff = 8'd0;
    base = trig_cnt;
    for (int p = 1; p <= 9; p++) begin
      trig_req = 4'b1000;
      tick();
      trig_req = 4'b0000;
      repeat (19) tick();
      chk("t2_ntrig", trig_cnt - base, p / 3);
      if (p % 3 == 0) chk("t2_src", {28'd0, last_src}, 32'h8);
    end

    // Coincident RF + PPS2.
    prescale = '0; src_en = 4'hF;
    base = trig_cnt; lbase = lost_pulses;
    trig_req = 4'b0101;
    tick();
    trig_req = 4'b0000;
    repeat (6) tick();
    chk("t3_ntrig", trig_cnt - base, 1);
    chk("t3_src", {28'd0, last_src}, 32'h5);
    chk("t3_no_lost", lost_pulses - lbase, 0);

    // Holdoff 10: pulses at k, k+5 (lost), k+12 (fires at k+14).
    holdoff = 8'd10;
    trig_req = 4'b0001; tick();  // after k+1
    trig_req = 4'b0000; tick();  // after k+2
    chk("t4_first", {31'd0, trig}, 1);
    repeat (3) tick();           // after k+5
    trig_req = 4'b0001; tick();  // after k+6
    trig_req = 4'b0000; tick();  // after k+7
    chk("t4_lost_pulse", {31'd0, lost}, 1);
    chk("t4_lost_count", {16'd0, lost_count}, 1);
    chk("t4_no_trig", {31'd0, trig}, 0);
    repeat (5) tick();           // after k+12
    trig_req = 4'b0001; tick();  // after k+13
    trig_req = 4'b0000;
    chk("t4_still_holdoff", {31'd0, trig}, 0);
    tick();                      // after k+14
    chk("t4_third", {31'd0, trig}, 1);
    holdoff = 8'd0;
    repeat (15) tick();

    // Dead time blocks and counts every qualified pulse.
    clr_lost = 1'b1; tick(); clr_lost = 1'b0;
    chk("t5_cleared", {16'd0, lost_count}, 0);
    dead = 1'b1; tick();
    chk("t5_busy_dead", {31'd0, busy}, 1);
    base = trig_cnt;
    for (int p = 0; p < 3; p++) begin
      trig_req = 4'b0001; tick();
      trig_req = 4'b0000; repeat (4) tick();
    end
    chk("t5_no_trig", trig_cnt - base, 0);
    chk("t5_lost_count", {16'd0, lost_count}, 3);
    chk("t5_busy", {31'd0, busy}, 1);
    dead = 1'b0; tick();
    chk("t5_busy_release", {31'd0, busy}, 0);
    trig_req = 4'b0001; tick();
    trig_req = 4'b0000; repeat (4) tick();
    chk("t5_after_release", trig_cnt - base, 1);

    // Saturation: alternate RF/PPS1 so every cycle carries one lost edge.
    dead = 1'b1; clr_lost = 1'b1; tick(); clr_lost = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      trig_req = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      tick();
    end
    repeat (3) tick();
    chk("t6_fffe", {16'd0, lost_count}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      trig_req = (trig_req == 4'b0001) ? 4'b0010 : 4'b0001;
      tick();
    end
    repeat (3) tick();
    chk("t6_saturated", {16'd0, lost_count}, 32'hFFFF);
    trig_req = (trig_req == 4'b0001) ? 4'b0010 : 4'b0001;
    tick();
    clr_lost = 1'b1; tick(); clr_lost = 1'b0;
    chk("t6_loss_with_clr", {31'd0, lost}, 1);
    chk("t6_clr_wins", {16'd0, lost_count}, 0);
    tick();
    chk("t6_stays_clear", {16'd0, lost_count}, 0);

    // Reset in the middle of a holdoff abandons it.
    dead = 1'b0; trig_req = 4'b0000; repeat (3) tick();
    holdoff = 8'd20;
    trig_req = 4'b0001; tick();
    trig_req = 4'b0000; tick();
    chk("t7_fire", {31'd0, trig}, 1);
    repeat (3) tick();
    chk("t7_busy_holdoff", {31'd0, busy}, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t7_busy_after_rst", {31'd0, busy}, 0);
    tick();
    trig_req = 4'b0001; tick();
    trig_req = 4'b0000; tick();
    chk("t7_refire", {31'd0, trig}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
